// File: rtl/bcd_convert_ctrl.sv
// Sequenced binary-to-BCD converter (shift-and-add-3) with a start/busy/done handshake.
// The packed BCD result and the overflow flag are registered and held until the next done.
module bcd_convert_ctrl #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD3  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     bin_q, bin_d;
   logic [BCD_W-1:0]     dig_q, dig_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 acc_q, acc_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic                 ovf_q, ovf_d;
   logic [SR_W-1:0]      sr_cat;
   logic [SR_W-1:0]      sr_shl;

   // Every digit >= 5 gets +3 so the following doubling carries correctly into the next digit.
   function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] d);
      logic [BCD_W-1:0] r;
      logic [3:0]       nib;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         nib = d[4*i +: 4];
         if (nib >= 4'd5) begin
            nib = nib + 4'd3;
         end
         r[4*i +: 4] = nib;
      end
      return r;
   endfunction

   assign sr_cat = {dig_q, bin_q};
   assign sr_shl = {sr_cat[SR_W-2:0], 1'b0};

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         bin_q   <= '0;
         dig_q   <= '0;
         cnt_q   <= '0;
         acc_q   <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         dig_q   <= dig_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      dig_d   = dig_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               bin_d   = bin;
               dig_d   = '0;
               acc_d   = 1'b0;
               cnt_d   = CNT_W'(WIDTH);
               state_d = ADD3;
            end
         end
         ADD3: begin
            dig_d   = add3_digits(dig_q);
            state_d = SHIFT;
         end
         SHIFT: begin
            {dig_d, bin_d} = sr_shl;
            acc_d = acc_q | dig_q[BCD_W-1];
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               // Result registers load on entry to DONE so they are valid alongside the done pulse.
               bcd_d   = sr_shl[SR_W-1 -: BCD_W];
               ovf_d   = acc_q | dig_q[BCD_W-1];
               state_d = DONE;
            end else begin
               state_d = ADD3;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign bcd      = bcd_q;
   assign overflow = ovf_q;

endmodule
